// File: rtl/intra_luma16x16_mode_decision.sv
// Intra16x16 luma mode decision: evaluates vertical, horizontal and DC predictors
// for one captured macroblock, one row of SAD per cycle, and reports the cheapest.
module intra_luma16x16_mode_decision #(
  parameter int unsigned MB_SIZE_L = 16,
  parameter int unsigned MB_SIZE_W = 16,
  parameter int unsigned SAD_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           mb         [MB_SIZE_L*MB_SIZE_W],
  input  logic [7:0]           toppixels  [MB_SIZE_W],
  input  logic [7:0]           leftpixels [MB_SIZE_L],
  input  logic                 top_avail,
  input  logic                 left_avail,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           best_mode,
  output logic [SAD_WIDTH-1:0] best_sad,
  output logic [7:0]           dc_value
);

  localparam int unsigned NPIX   = MB_SIZE_L * MB_SIZE_W;
  localparam int unsigned ROW_W  = $clog2(MB_SIZE_L);
  localparam int unsigned COL_W  = $clog2(MB_SIZE_W);
  localparam int unsigned PSUM_W = 12;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DCCALC = 2'd1,
    S_ACCUM  = 2'd2,
    S_DECIDE = 2'd3
  } state_e;

  state_e               state_q;
  logic [ROW_W-1:0]     row_q;
  logic [SAD_WIDTH-1:0] sad_v_q, sad_h_q, sad_d_q;

  logic [7:0] mb_q   [NPIX];
  logic [7:0] top_q  [MB_SIZE_W];
  logic [7:0] left_q [MB_SIZE_L];
  logic       top_av_q, left_av_q;

  logic [PSUM_W-1:0]    sum_t_c, sum_l_c;
  logic [PSUM_W:0]      dc_both_c;
  logic [PSUM_W-1:0]    dc_one_t_c, dc_one_l_c;
  logic [7:0]           dc_calc_c;
  logic [PSUM_W-1:0]    row_v_c, row_h_c, row_d_c;
  logic [1:0]           dec_mode_c;
  logic [SAD_WIDTH-1:0] dec_sad_c;

  function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Input snapshot taken on start acceptance; upstream may change afterwards.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      mb_q      <= mb;
      top_q     <= toppixels;
      left_q    <= leftpixels;
      top_av_q  <= top_avail;
      left_av_q <= left_avail;
    end
  end

  // DC predictor from neighbour sums
  always_comb begin
    sum_t_c = '0;
    sum_l_c = '0;
    for (int i = 0; i < MB_SIZE_W; i++) sum_t_c += PSUM_W'(top_q[COL_W'(i)]);
    for (int i = 0; i < MB_SIZE_L; i++) sum_l_c += PSUM_W'(left_q[ROW_W'(i)]);
    dc_both_c  = ((PSUM_W+1)'(sum_t_c) + (PSUM_W+1)'(sum_l_c) + (PSUM_W+1)'(16)) >> 5;
    dc_one_t_c = (sum_t_c + PSUM_W'(8)) >> 4;
    dc_one_l_c = (sum_l_c + PSUM_W'(8)) >> 4;
    if (top_av_q && left_av_q) dc_calc_c = 8'(dc_both_c);
    else if (top_av_q)         dc_calc_c = 8'(dc_one_t_c);
    else if (left_av_q)        dc_calc_c = 8'(dc_one_l_c);
    else                       dc_calc_c = 8'd128;
  end

  // Per-row partial SADs for the row selected by row_q
  always_comb begin
    row_v_c = '0;
    row_h_c = '0;
    row_d_c = '0;
    for (int c = 0; c < MB_SIZE_W; c++) begin
      row_v_c += PSUM_W'(absdiff(mb_q[{row_q, COL_W'(c)}], top_q[COL_W'(c)]));
      row_h_c += PSUM_W'(absdiff(mb_q[{row_q, COL_W'(c)}], left_q[row_q]));
      row_d_c += PSUM_W'(absdiff(mb_q[{row_q, COL_W'(c)}], dc_value));
    end
  end

  // Candidates in ascending priority; '<=' lets the higher-priority mode win ties
  always_comb begin
    dec_mode_c = 2'd2;
    dec_sad_c  = sad_d_q;
    if (left_av_q && sad_h_q <= dec_sad_c) begin
      dec_mode_c = 2'd1;
      dec_sad_c  = sad_h_q;
    end
    if (top_av_q && sad_v_q <= dec_sad_c) begin
      dec_mode_c = 2'd0;
      dec_sad_c  = sad_v_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      best_mode <= 2'd2;
      best_sad  <= '0;
      dc_value  <= 8'd128;
      sad_v_q   <= '0;
      sad_h_q   <= '0;
      sad_d_q   <= '0;
      row_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sad_v_q <= '0;
            sad_h_q <= '0;
            sad_d_q <= '0;
            row_q   <= '0;
            busy    <= 1'b1;
            state_q <= S_DCCALC;
          end
        end
        S_DCCALC: begin
          dc_value <= dc_calc_c;
          state_q  <= S_ACCUM;
        end
        S_ACCUM: begin
          sad_v_q <= sad_v_q + SAD_WIDTH'(row_v_c);
          sad_h_q <= sad_h_q + SAD_WIDTH'(row_h_c);
          sad_d_q <= sad_d_q + SAD_WIDTH'(row_d_c);
          row_q   <= row_q + ROW_W'(1);
          if (row_q == ROW_W'(MB_SIZE_L - 1)) state_q <= S_DECIDE;
        end
        S_DECIDE: begin
          best_mode <= dec_mode_c;
          best_sad  <= dec_sad_c;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intra_luma16x16_mode_decision.sv
// Scoreboard bench for intra_luma16x16_mode_decision: directed cases from the
// mode rules plus randomized macroblocks, checked against a plain-arithmetic model.
module tb_intra_luma16x16_mode_decision;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  mb_s   [256];
  logic [7:0]  top_s  [16];
  logic [7:0]  left_s [16];
  logic        top_av, left_av;
  logic        busy, done;
  logic [1:0]  best_mode;
  logic [15:0] best_sad;
  logic [7:0]  dc_value;

  intra_luma16x16_mode_decision #(
    .MB_SIZE_L(16), .MB_SIZE_W(16), .SAD_WIDTH(16)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .mb         (mb_s),
    .toppixels  (top_s),
    .leftpixels (left_s),
    .top_avail  (top_av),
    .left_avail (left_av),
    .busy       (busy),
    .done       (done),
    .best_mode  (best_mode),
    .best_sad   (best_sad),
    .dc_value   (dc_value)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int mode;
    int sad;
    int dc;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic done_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: predictors and SADs straight from the definitions
  function automatic exp_t model();
    exp_t e;
    int st = 0, sl = 0, dc, sv = 0, sh = 0, sd = 0, p;
    int cand_m[$], cand_s[$];
    for (int i = 0; i < 16; i++) begin
      st += int'(top_s[4'(i)]);
      sl += int'(left_s[4'(i)]);
    end
    if (top_av && left_av) dc = (st + sl + 16) / 32;
    else if (top_av)       dc = (st + 8) / 16;
    else if (left_av)      dc = (sl + 8) / 16;
    else                   dc = 128;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        p   = int'(mb_s[8'(r * 16 + c)]);
        sv += iabs(p - int'(top_s[4'(c)]));
        sh += iabs(p - int'(left_s[4'(r)]));
        sd += iabs(p - dc);
      end
    if (top_av)  begin cand_m.push_back(0); cand_s.push_back(sv); end
    if (left_av) begin cand_m.push_back(1); cand_s.push_back(sh); end
    cand_m.push_back(2); cand_s.push_back(sd);
    e.mode = cand_m[0];
    e.sad  = cand_s[0];
    for (int k = 1; k < cand_m.size(); k++)
      if (cand_s[k] < e.sad) begin
        e.mode = cand_m[k];
        e.sad  = cand_s[k];
      end
    e.dc  = dc;
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      check("done_single_cycle", int'(done_prev), 0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("best_mode", int'(best_mode), e.mode);
        check("best_sad", int'(best_sad), e.sad);
        check("dc_value", int'(dc_value), e.dc);
        check("latency", cyc, e.cyc);
        check("busy_at_done", int'(busy), 0);
      end
    end
    done_prev = done;
  end

  task automatic fill(input int v, input int t, input int l, input logic ta, input logic la);
    for (int i = 0; i < 256; i++) mb_s[8'(i)] = 8'(v);
    for (int i = 0; i < 16; i++) begin
      top_s[4'(i)]  = 8'(t);
      left_s[4'(i)] = 8'(l);
    end
    top_av  = ta;
    left_av = la;
  endtask

  task automatic fill_random();
    int kind, v;
    kind = int'($urandom_range(0, 3));
    for (int i = 0; i < 16; i++) begin
      top_s[4'(i)]  = 8'($urandom_range(0, 255));
      left_s[4'(i)] = 8'($urandom_range(0, 255));
    end
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        case (kind)
          0:       v = int'($urandom_range(0, 255));
          1:       v = int'(left_s[4'(r)]) + int'($urandom_range(0, 6)) - 3;
          2:       v = int'(top_s[4'(c)]) + int'($urandom_range(0, 6)) - 3;
          default: v = 120 + int'($urandom_range(0, 10));
        endcase
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        mb_s[8'(r * 16 + c)] = 8'(v);
      end
    top_av  = 1'($urandom_range(0, 1));
    left_av = 1'($urandom_range(0, 1));
  endtask

  // Waits for idle, issues start and records the expectation; returns one negedge after E0
  task automatic run_mb();
    exp_t e;
    int   w = 0;
    while (busy && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (busy) check("idle_wait_timeout", int'(busy), 0);
    e     = model();
    e.cyc = cyc + 19;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    start = 1'b0;
    fill(0, 0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_mode", int'(best_mode), 2);
    check("reset_sad", int'(best_sad), 0);
    check("reset_dc", int'(dc_value), 128);
    rst_n = 1'b1;
    @(negedge clk);

    fill(100, 100, 50, 1'b1, 1'b1);  run_mb();  // vertical win
    fill(0, 0, 0, 1'b1, 1'b1);
    for (int r = 0; r < 16; r++) begin
      left_s[4'(r)] = 8'(10 * r);
      for (int c = 0; c < 16; c++) mb_s[8'(r * 16 + c)] = 8'(10 * r);
    end
    run_mb();                                    // horizontal win
    fill(200, 0, 0, 1'b0, 1'b0);  run_mb();     // no neighbours
    fill(64, 64, 64, 1'b1, 1'b1); run_mb();     // three-way tie

    // Second start at E5 must be ignored; next start lands at E19
    fill_random();
    run_mb();
    repeat (4) @(negedge clk);
    fill_random();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_mb();

    // Reset during ACCUM abandons the macroblock
    fill_random();
    run_mb();
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_mode", int'(best_mode), 2);
    check("midreset_sad", int'(best_sad), 0);
    check("midreset_dc", int'(dc_value), 128);
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    check("midreset_no_done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    fill(90, 20, 90, 1'b1, 1'b1); run_mb();

    for (int n = 0; n < 16; n++) begin
      fill_random();
      run_mb();
    end

    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/intra_luma16x16_mode_decision.md
# intra_luma16x16_mode_decision

Mode-decision stage that sits directly downstream of the 16x16 luma macroblock extractor. It takes one extracted macroblock plus its top and left neighbour pixels and evaluates the H.264 Intra16x16 vertical, horizontal and DC predictors. It accumulates the sum of absolute differences (SAD) for each predictor one row per cycle, then reports the cheapest mode, its SAD and the DC predictor value to the residual/transform stage.

## Interface
- MB_SIZE_L, 16, macroblock rows; only 16 supported
- MB_SIZE_W, 16, macroblock columns; only 16 supported
- SAD_WIDTH, 16, SAD accumulator width; 16 holds the worst case of 256*255 = 65280
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low; forces the IDLE state
- start  input  1  request to evaluate the currently presented macroblock
- mb  input  8 x 256 (unpacked)  macroblock pixels, index row*16+col
- toppixels  input  8 x 16 (unpacked)  row above the macroblock, index = column
- leftpixels  input  8 x 16 (unpacked)  column left of the macroblock, index = row
- top_avail  input  1  top neighbours are real pixels; 0 means the macroblock is at the frame top
- left_avail  input  1  left neighbours are real pixels; 0 means the macroblock is at the frame left
- busy  output  1  high from start acceptance until the result is registered
- done  output  1  one-cycle pulse; results valid from this cycle on
- best_mode  output  2  0 = vertical, 1 = horizontal, 2 = DC
- best_sad  output  SAD_WIDTH  SAD of best_mode
- dc_value  output  8  DC predictor used for this macroblock

## Operation
- States: IDLE, DCCALC, ACCUM, DECIDE.
- **IDLE**
  - When start=1, register mb, toppixels, leftpixels, top_avail and left_avail into internal copies.
  - Clear the three SAD accumulators and the row counter, set busy, then go to DCCALC.
  - The upstream extractor may change its outputs after the start edge without effect on the result.
- **DCCALC**
  - Compute sumT as the 12-bit sum of the 16 top pixels, and sumL as the 12-bit sum of the 16 left pixels.
  - dc_value is chosen as follows:
    - both neighbours available: (sumT+sumL+16)>>5
    - top only: (sumT+8)>>4
    - left only: (sumL+8)>>4
    - neither: 128
  - Register dc_value, then go to ACCUM.
- **ACCUM** runs 16 cycles; row counter r runs 0..15. Each cycle, over the 16 pixels p of row r:
  - sadV += sum |p[c] - top[c]|
  - sadH += sum |p[c] - left[r]|
  - sadD += sum |p[c] - dc_value|
  - Per-row partial sums are 12 bits, zero-extended before accumulating.
  - After r=15, go to DECIDE.
- **DECIDE**
  - Candidate set: DC always; vertical only if top_avail; horizontal only if left_avail.
  - Pick the minimum SAD among the candidates. On a tie the lower mode number wins, giving priority V > H > DC.
  - Register best_mode and best_sad, pulse done, clear busy, return to IDLE.
- start is ignored while busy=1; no queuing.
- Outputs best_mode, best_sad and dc_value hold their values until the next DECIDE.
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, best_mode=2, best_sad=0, dc_value=128, accumulators and row counter=0. A reset mid-operation abandons the macroblock and produces no done pulse.

## Timing
- Start is accepted at rising edge E0 with state IDLE and start=1. busy=1 from E0.
- dc_value is registered at E1.
- Row 0 is accumulated at E2, and row 15 at E17.
- best_mode, best_sad and done=1 are registered at E18. busy=0 from E18.
- done is high for exactly one cycle, the cycle after E18. Latency is 18 cycles.
- A start held high at E18 is not accepted. The next acceptance can occur at E19 at the earliest, giving a throughput of 1 macroblock per 19 cycles.
- The dc_value output changes at E1 of each macroblock. It must not be sampled as a final value before done.

## Test plan
- **Vertical win:** mb all 100, top all 100, left all 50, both available. Expect best_mode=0, best_sad=0, dc_value=75, and done exactly 18 cycles after the start edge.
- **Horizontal win:** row r of mb = 10*r, left[r]=10*r, top all 0, both available.
  - Expected SADs: sadV = 16*sum(10r) = 19200, sadH=0.
  - Expect best_mode=1, best_sad=0.
- **No neighbours:** top_avail=0, left_avail=0, mb all 200, neighbour inputs all 0.
  - Expect dc_value=128, best_mode=2, best_sad=256*72=18432.
  - V and H must be excluded despite their SAD of 51200.
- **Tie-break:** mb all 64, top all 64, left all 64, both available. All three SADs are 0; expect best_mode=0.
- **Busy/start:** pulse start again at E5 with different mb. Expect it to be ignored and the result to match the first macroblock; then a start at E19 is accepted.
- **Reset mid-operation:** assert reset low during ACCUM (E10).
  - While reset is low: busy=0 immediately and asynchronously, no done pulse, best_mode=2, best_sad=0, dc_value=128.
  - A subsequent start after reset is released produces a correct result.
